// File: rtl/seq_det_pkg.sv
// Shared defaults and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

  localparam int unsigned DEF_PATTERN_W = 5;
  localparam logic [31:0] DEF_PATTERN   = 32'b10110;
  localparam int unsigned DEF_CNT_W     = 8;

  // Bits needed to hold values 0..v-1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Control/data bundle of the serial pattern detector (stimulus side = master).
interface seq_detector_param_if #(
  parameter int unsigned PATTERN_W = 5,
  parameter int unsigned CNT_W     = 8
);
  logic                 en;
  logic                 j;
  logic                 ovl;
  logic                 pat_ld;
  logic [PATTERN_W-1:0] pat_in;
  logic                 cnt_clr;
  logic                 w;
  logic [CNT_W-1:0]     match_cnt;

  modport master (output en, j, ovl, pat_ld, pat_in, cnt_clr, input w, match_cnt);
  modport slave  (input en, j, ovl, pat_ld, pat_in, cnt_clr, output w, match_cnt);
endinterface

// File: rtl/seq_match_cnt.sv
// Saturating match counter with synchronous clear; a coincident inc lands as 1.
module seq_match_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt;
    if (clr) cnt_d = CNT_W'(inc);
    else if (inc && (cnt != {CNT_W{1'b1}})) cnt_d = cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else      cnt <= cnt_d;
  end
endmodule

// File: rtl/seq_detector_param.sv
// Parametrised Moore serial pattern detector with reloadable pattern and overlap control.
// Optional saturating match counter enabled by macro SEQ_MATCH_CNT_EN.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned          PATTERN_W = DEF_PATTERN_W,
  parameter logic [PATTERN_W-1:0] PATTERN   = PATTERN_W'(DEF_PATTERN),
  parameter int unsigned          CNT_W     = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_detector_param_if.slave  bus
);
  localparam int unsigned      FILL_W   = clog2(PATTERN_W + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_W);
  localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PATTERN_W - 1);

  logic [PATTERN_W-1:0] hist_q, hist_d;
  logic [PATTERN_W-1:0] pat_q, pat_d;
  logic [PATTERN_W-1:0] nxt_c;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic                 w_q, w_d;
  logic                 hit_c;

  // fill counts fresh bits, so stale history can never complete a match
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    w_d    = 1'b0;
    hit_c  = 1'b0;
    nxt_c  = {hist_q[PATTERN_W-2:0], bus.j};
    if (bus.pat_ld) begin
      pat_d  = bus.pat_in;
      fill_d = '0;
    end else if (bus.en) begin
      hist_d = nxt_c;
      hit_c  = (fill_q >= FILL_ARM) && (nxt_c == pat_q);
      w_d    = hit_c;
      if (hit_c && !bus.ovl)     fill_d = '0;
      else if (fill_q != FILL_MAX) fill_d = fill_q + FILL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= PATTERN;
      w_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      w_q    <= w_d;
    end
  end

  assign bus.w = w_q;

`ifdef SEQ_MATCH_CNT_EN
  seq_match_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (bus.cnt_clr),
    .inc (hit_c),
    .cnt (bus.match_cnt)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = bus.cnt_clr;
  assign bus.match_cnt  = CNT_W'(0);
`endif
endmodule
